// File: rtl/soc_system_pio_gen2_pkg.sv
// Shared definitions for the general-purpose PIO block: register addresses and
// the encodings that choose which input transition is captured.
package soc_system_pio_pkg;

  // Word addresses of the slave register map; 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_RSVD6   = 3'd6,
    ADDR_RSVD7   = 3'd7
  } pio_addr_e;

  // Which transition of a synchronised input sets its capture flag.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_gen2_if.sv
// Avalon-MM slave bus bundle for the PIO: strobes are active low, read data
// arrives one cycle after the read strobe.
interface soc_system_pio_gen2_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_gen2_sync_edge.sv
// Input conditioning for the PIO: two-flop synchroniser for asynchronous pins,
// one extra delay stage, and a per-bit single-cycle edge pulse.
module pio_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_s,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync_meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] delay_reg;

  // Synchroniser and delay stages; cleared on reset so they refill from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
      delay_reg     <= '0;
    end else begin
      sync_meta_reg <= in_port;
      sync_reg      <= sync_meta_reg;
      delay_reg     <= sync_reg;
    end
  end

  assign in_s = sync_reg;

  // Edge selection is fixed at elaboration; every bit is captured whatever
  // its direction setting in the parent.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_pulse[gi] = ~sync_reg[gi] & delay_reg[gi];
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_pulse[gi] = sync_reg[gi] ^ delay_reg[gi];
    end else begin : g_rise
      assign edge_pulse[gi] = sync_reg[gi] & ~delay_reg[gi];
    end
  end

endmodule

// File: rtl/soc_system_pio_gen2.sv
// General-purpose Avalon-MM PIO: per-bit direction, atomic set/clear of the
// output register, synchronised inputs with sticky edge capture, and a
// maskable level interrupt.
module soc_system_pio_gen2
  import soc_system_pio_pkg::*;
#(
  parameter int          WIDTH     = 10,
  parameter logic [31:0] OUT_RESET = 32'h0,
  parameter logic [31:0] DIR_RESET = '1,
  parameter int          EDGE_TYPE = EDGE_RISE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  soc_system_pio_gen2_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     oe,
  output logic                 irq
);

  logic [WIDTH-1:0] out_reg,  out_next;
  logic [WIDTH-1:0] dir_reg,  dir_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] ec_reg,   ec_next;
  logic             irq_reg,  irq_next;
  logic [31:0]      readdata_reg, readdata_next;

  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] data_view;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             rd_en;
  pio_addr_e        addr;
  logic             unused_writedata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;
  assign addr  = pio_addr_e'(bus.address);
  assign wd    = bus.writedata[WIDTH-1:0];
  // Bits above WIDTH are deliberately ignored on writes.
  assign unused_writedata = ^bus.writedata;

  pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_s       (in_s),
    .edge_pulse (edge_pulse)
  );

  // DATA reads show the driven value for outputs and the pin for inputs.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_view
    assign data_view[gi] = dir_reg[gi] ? out_reg[gi] : in_s[gi];
  end

  // Register writes, edge-capture update and interrupt level.
  always_comb begin
    out_next  = out_reg;
    dir_next  = dir_reg;
    mask_next = mask_reg;
    ec_clr    = '0;
    if (wr_en) begin
      case (addr)
        ADDR_DATA:    out_next  = wd;
        ADDR_DIR:     dir_next  = wd;
        ADDR_IRQMASK: mask_next = wd;
        ADDR_EDGECAP: ec_clr    = wd;
        ADDR_OUTSET:  out_next  = out_reg | wd;
        ADDR_OUTCLR:  out_next  = out_reg & ~wd;
        default:      ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear so no event is dropped.
    ec_next  = (ec_reg & ~ec_clr) | edge_pulse;
    irq_next = |(ec_reg & mask_reg);
  end

  // Read mux; the value is sampled from pre-write state and held until the
  // next read.
  always_comb begin
    readdata_next = readdata_reg;
    if (rd_en) begin
      readdata_next = '0;
      case (addr)
        ADDR_DATA:    readdata_next[WIDTH-1:0] = data_view;
        ADDR_DIR:     readdata_next[WIDTH-1:0] = dir_reg;
        ADDR_IRQMASK: readdata_next[WIDTH-1:0] = mask_reg;
        ADDR_EDGECAP: readdata_next[WIDTH-1:0] = ec_reg;
        default:      ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_reg      <= OUT_RESET[WIDTH-1:0];
      dir_reg      <= DIR_RESET[WIDTH-1:0];
      mask_reg     <= '0;
      ec_reg       <= '0;
      irq_reg      <= 1'b0;
      readdata_reg <= '0;
    end else begin
      out_reg      <= out_next;
      dir_reg      <= dir_next;
      mask_reg     <= mask_next;
      ec_reg       <= ec_next;
      irq_reg      <= irq_next;
      readdata_reg <= readdata_next;
    end
  end

  assign out_port     = out_reg;
  assign oe           = dir_reg;
  assign irq          = irq_reg;
  assign bus.readdata = readdata_reg;

endmodule

// File: tb/tb_soc_system_pio_gen2.sv
// Self-checking bench for the PIO: a rising-edge instance (dut0) and a
// falling-edge instance (dut1). Reads push their expected value to a
// scoreboard queue; a monitor pops and compares when readdata is valid.
module tb_soc_system_pio_gen2;
  import soc_system_pio_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port0, in_port1;
  logic [W-1:0] out_port0, out_port1, oe0, oe1;
  logic         irq0, irq1;

  soc_system_pio_gen2_if bus0 ();
  soc_system_pio_gen2_if bus1 ();

  always #5 clk = ~clk;

  soc_system_pio_gen2 #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port0),
    .out_port(out_port0), .oe(oe0), .irq(irq0)
  );

  soc_system_pio_gen2 #(.WIDTH(W), .EDGE_TYPE(EDGE_FALL)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port1),
    .out_port(out_port1), .oe(oe1), .irq(irq1)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb0[$];
  sb_t sb1[$];
  logic rd_seen0 = 1'b0;
  logic rd_seen1 = 1'b0;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [31:0] d,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = e; v.name = n;
    return v;
  endfunction

  // Monitor: readdata is valid on the negedge following the sampling edge.
  always @(posedge clk) begin
    rd_seen0 <= bus0.chipselect & ~bus0.read_n & reset_n;
    rd_seen1 <= bus1.chipselect & ~bus1.read_n & reset_n;
  end

  always @(negedge clk) begin
    sb_t e;
    if (rd_seen0) begin
      if (sb0.size() == 0) check("sb0_unexpected_read", bus0.readdata, 32'hx);
      else begin e = sb0.pop_front(); check(e.name, bus0.readdata, e.exp); end
    end
    if (rd_seen1) begin
      if (sb1.size() == 0) check("sb1_unexpected_read", bus1.readdata, 32'hx);
      else begin e = sb1.pop_front(); check(e.name, bus1.readdata, e.exp); end
    end
  end

  // All bus tasks are entered on a negedge and return on the next negedge.
  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    $display("dut0 WR addr=%0d data=0x%08h", a, d);
    bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    @(negedge clk);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
  endtask

  task automatic rd0(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    $display("dut0 RD addr=%0d expect=0x%08h (%s)", a, exp, name);
    e.exp = exp; e.name = name; sb0.push_back(e);
    bus0.address = a; bus0.chipselect = 1'b1; bus0.read_n = 1'b0;
    @(negedge clk);
    bus0.chipselect = 1'b0; bus0.read_n = 1'b1;
  endtask

  task automatic rd1(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    $display("dut1 RD addr=%0d expect=0x%08h (%s)", a, exp, name);
    e.exp = exp; e.name = name; sb1.push_back(e);
    bus1.address = a; bus1.chipselect = 1'b1; bus1.read_n = 1'b0;
    @(negedge clk);
    bus1.chipselect = 1'b0; bus1.read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b1, ADDR_DATA,    32'h0000_00F0, 32'h0,   "w_data");
    vecs[1]  = mk(1'b1, ADDR_OUTSET,  32'h0000_0003, 32'h0,   "w_outset");
    vecs[2]  = mk(1'b1, ADDR_OUTCLR,  32'h0000_0010, 32'h0,   "w_outclr");
    vecs[3]  = mk(1'b0, ADDR_DATA,    32'h0,         32'h0E3, "atomic_data");
    vecs[4]  = mk(1'b0, ADDR_OUTSET,  32'h0,         32'h0,   "outset_reads0");
    vecs[5]  = mk(1'b0, ADDR_OUTCLR,  32'h0,         32'h0,   "outclr_reads0");
    vecs[6]  = mk(1'b1, ADDR_RSVD6,   32'h0000_0123, 32'h0,   "w_rsvd6");
    vecs[7]  = mk(1'b0, ADDR_RSVD6,   32'h0,         32'h0,   "rsvd6_reads0");
    vecs[8]  = mk(1'b0, ADDR_RSVD7,   32'h0,         32'h0,   "rsvd7_reads0");
    vecs[9]  = mk(1'b1, ADDR_IRQMASK, 32'hFFFF_F155, 32'h0,   "w_mask_wide");
    vecs[10] = mk(1'b0, ADDR_IRQMASK, 32'h0,         32'h155, "mask_upper_dropped");
    vecs[11] = mk(1'b1, ADDR_IRQMASK, 32'h0,         32'h0,   "w_mask0");
    vecs[12] = mk(1'b0, ADDR_DIR,     32'h0,         32'h3FF, "dir_unchanged");
    vecs[13] = mk(1'b0, ADDR_DATA,    32'h0,         32'h0E3, "data_after_rsvd");

    reset_n = 1'b0;
    bus0.chipselect = 1'b0; bus0.read_n = 1'b1; bus0.write_n = 1'b1;
    bus0.address = '0; bus0.writedata = '0;
    bus1.chipselect = 1'b0; bus1.read_n = 1'b1; bus1.write_n = 1'b1;
    bus1.address = '0; bus1.writedata = '0;
    in_port0 = '0; in_port1 = '0;

    // Reset state.
    idle(3);
    check("rst_out_port", 32'(out_port0), 32'h0);
    check("rst_oe", 32'(oe0), 32'h3FF);
    check("rst_irq", 32'(irq0), 32'h0);
    check("rst_readdata", bus0.readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    rd0(ADDR_DIR, 32'h3FF, "rst_dir_read");

    // Register map and atomic set/clear.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) wr0(vecs[i].addr, vecs[i].data);
      else rd0(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    check("atomic_out_port", 32'(out_port0), 32'h0E3);

    // Mixed direction: low nibble driven, upper bits from pins.
    wr0(ADDR_DIR, 32'h00F);
    wr0(ADDR_DATA, 32'h005);
    in_port0 = 10'h2A0;
    idle(3);
    check("mixed_oe", 32'(oe0), 32'h00F);
    rd0(ADDR_DATA, 32'h2A5, "mixed_data");
    rd0(ADDR_EDGECAP, 32'h2A0, "mixed_edgecap");

    // Read and write together: read returns the pre-write value.
    begin
      sb_t e;
      e.exp = 32'h2A5; e.name = "rdwr_pre_value"; sb0.push_back(e);
      $display("dut0 RD+WR addr=0 data=0x0000000a expect=0x000002a5");
      bus0.address = ADDR_DATA; bus0.writedata = 32'h00A;
      bus0.chipselect = 1'b1; bus0.read_n = 1'b0; bus0.write_n = 1'b0;
      @(negedge clk);
      bus0.chipselect = 1'b0; bus0.read_n = 1'b1; bus0.write_n = 1'b1;
    end
    rd0(ADDR_DATA, 32'h2AA, "rdwr_post_value");

    // Quiet the pins and clear all captured edges.
    in_port0 = '0;
    idle(4);
    wr0(ADDR_EDGECAP, 32'h3FF);
    rd0(ADDR_EDGECAP, 32'h0, "edgecap_cleared");

    // Edge to interrupt latency, then W1C.
    wr0(ADDR_IRQMASK, 32'h001);
    in_port0[0] = 1'b1;
    idle(3);
    check("irq_not_yet_c3", 32'(irq0), 32'h0);
    idle(1);
    check("irq_set_c4", 32'(irq0), 32'h1);
    rd0(ADDR_EDGECAP, 32'h001, "edge_bit0");
    wr0(ADDR_EDGECAP, 32'h001);
    check("irq_w1c_c1", 32'(irq0), 32'h1);
    idle(1);
    check("irq_w1c_c2", 32'(irq0), 32'h0);

    // Collision: W1C lands on the same edge as a new capture.
    in_port0[0] = 1'b0;
    idle(3);
    in_port0[0] = 1'b1;
    idle(4);
    check("coll_pre_irq", 32'(irq0), 32'h1);
    in_port0[0] = 1'b0;
    idle(3);
    in_port0[0] = 1'b1;
    idle(2);
    wr0(ADDR_EDGECAP, 32'h001);
    check("coll_irq_c1", 32'(irq0), 32'h1);
    idle(1);
    check("coll_irq_c2", 32'(irq0), 32'h1);
    rd0(ADDR_EDGECAP, 32'h001, "coll_edgecap");
    wr0(ADDR_EDGECAP, 32'h001);
    rd0(ADDR_EDGECAP, 32'h0, "plain_w1c");

    // Falling-edge instance.
    in_port1[2] = 1'b1;
    idle(5);
    rd1(ADDR_EDGECAP, 32'h0, "fall_ignores_rise");
    in_port1[2] = 1'b0;
    idle(5);
    rd1(ADDR_EDGECAP, 32'h004, "fall_captured");

    // Reset during a read: pending data is discarded.
    rd0(ADDR_DIR, 32'h00F, "dir_before_reset");
    reset_n = 1'b0;
    bus0.address = ADDR_DATA; bus0.chipselect = 1'b1; bus0.read_n = 1'b0;
    @(negedge clk);
    bus0.chipselect = 1'b0; bus0.read_n = 1'b1;
    check("midrst_readdata", bus0.readdata, 32'h0);
    check("midrst_out_port", 32'(out_port0), 32'h0);
    check("midrst_oe", 32'(oe0), 32'h3FF);
    check("midrst_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    idle(2);

    check("sb0_drained", 32'(sb0.size()), 32'h0);
    check("sb1_drained", 32'(sb1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
